win_parity_sched: RTL and testbench

WIN_PARITY_SCHED -- requirements
Module: win_parity_sched

---
 rtl/win_parity_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/win_parity_sched.sv | 138 +++++++++++++
 tb/tb_win_parity_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/win_parity_pkg.sv
// Shared types and default sizing for the windowed-parity scheduler.
// Holds the FSM state encoding and the default lane count / window length.
package win_parity_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_WIN   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans lanes starting at rr and grants
// the first requester it meets, producing a one-hot (or all-zero) grant.
module rr_arbiter
  import win_parity_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  localparam int ID_W  = $clog2(LANES)
) (
  input  logic [LANES-1:0] req,
  input  logic [ID_W-1:0]  rr,
  output logic [LANES-1:0] grant
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = ID_W'((int'(rr) + i) % LANES);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/win_parity_sched.sv
// Round-robin scheduler that grants one serial lane, XORs WIN of its bits and
// holds the parity until consumed. Define WIN_PARITY_SCHED_ABORT_EN to abandon
// a window when the winner withdraws its request during collection.
module win_parity_sched
  import win_parity_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int WIN   = DEF_WIN,
  localparam int ID_W  = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] req,
  input  logic [LANES-1:0] dat,
  output logic [LANES-1:0] gnt,
  output logic             busy,
  output logic             res_valid,
  output logic             res_par,
  output logic [ID_W-1:0]  res_lane,
  input  logic             res_ready
);

  localparam int CNT_W = $clog2(WIN + 1);

  state_t           state, state_nxt;
  logic [LANES-1:0] gnt_nxt;
  logic [ID_W-1:0]  lane_nxt;
  logic             par_nxt;
  logic             valid_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ID_W-1:0]  rr, rr_nxt;
  logic [LANES-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             abort;

  rr_arbiter #(.LANES(LANES)) u_arb (
    .req   (req),
    .rr    (rr),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int j = 0; j < LANES; j++) begin
      if (arb_grant[j]) arb_idx = ID_W'(j);
    end
  end

`ifdef WIN_PARITY_SCHED_ABORT_EN
  assign abort = (state == COLLECT) && !req[res_lane];
`else
  assign abort = 1'b0;
`endif

  assign busy = (state != IDLE);

  // res_par doubles as the running accumulator and res_lane as the winner index,
  // so the result is already in place when HOLD is entered.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    lane_nxt  = res_lane;
    par_nxt   = res_par;
    valid_nxt = res_valid;
    cnt_nxt   = cnt;
    rr_nxt    = rr;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          gnt_nxt   = arb_grant;
          lane_nxt  = arb_idx;
          par_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (abort) begin
          gnt_nxt   = '0;
          par_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          par_nxt = res_par ^ dat[res_lane];
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIN - 1)) begin
            gnt_nxt   = '0;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        gnt_nxt = '0;
        if (res_ready) begin
          valid_nxt = 1'b0;
          rr_nxt    = (res_lane == ID_W'(LANES - 1)) ? '0 : res_lane + ID_W'(1);
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      res_lane  <= '0;
      res_par   <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
      rr        <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      res_lane  <= lane_nxt;
      res_par   <= par_nxt;
      res_valid <= valid_nxt;
      cnt       <= cnt_nxt;
      rr        <= rr_nxt;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_collect_only: assert property (@(posedge clk) disable iff (rst)
    (state != COLLECT) |-> (gnt == '0));
  a_valid_in_hold: assert property (@(posedge clk) disable iff (rst)
    res_valid == (state == HOLD));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD && !res_ready) |=> (res_valid && $stable(res_par) && $stable(res_lane)));

endmodule

// File: tb/tb_win_parity_sched.sv
// Directed bench for win_parity_sched (LANES=4, WIN=3) with hand-computed
// expectations; abort-path expectations follow WIN_PARITY_SCHED_ABORT_EN.
module tb_win_parity_sched;

  localparam int LANES = 4;
  localparam int WIN   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dat;
  logic [3:0] gnt;
  logic       busy;
  logic       res_valid;
  logic       res_par;
  logic [1:0] res_lane;
  logic       res_ready;

  int checks   = 0;
  int failures = 0;

  win_parity_sched #(.LANES(LANES), .WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dat       (dat),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_par   (res_par),
    .res_lane  (res_lane),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic rd);
    req       = r;
    dat       = d;
    res_ready = rd;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'h0);
    checkOutput({tag, "_par"}, 32'(res_par), 32'h0);
    checkOutput({tag, "_lane"}, 32'(res_lane), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Continuous requests on all lanes: grants rotate 0,1,2,3 and wrap to 0.
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(1 << (g % 4)));
      repeat (WIN) tick();
      checkOutput($sformatf("rr_valid%0d", g), 32'(res_valid), 32'h1);
      checkOutput($sformatf("rr_lane%0d", g), 32'(res_lane), 32'(g % 4));
      if (g == 4) req = 4'b0000;
      tick();
      checkOutput($sformatf("rr_idle%0d", g), 32'(busy), 32'h0);
    end

    // Lane 0 window, dat[0] = 1,1,0 -> parity 0; other lanes carry noise.
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    tick();
    checkOutput("a_gnt", 32'(gnt), 32'h1);
    checkOutput("a_busy1", 32'(busy), 32'h1);
    applyStimulus(4'b0000, 4'b0101, 1'b1);
    tick();
    checkOutput("a_novalid", 32'(res_valid), 32'h0);
    checkOutput("a_gnt_collect", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 4'b1011, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b1110, 1'b1);
    tick();
    checkOutput("a_valid", 32'(res_valid), 32'h1);
    checkOutput("a_par", 32'(res_par), 32'h0);
    checkOutput("a_lane", 32'(res_lane), 32'h0);
    checkOutput("a_gnt_hold", 32'(gnt), 32'h0);
    checkOutput("a_busy4", 32'(busy), 32'h1);
    tick();
    checkOutput("a_released", 32'(res_valid), 32'h0);
    checkOutput("a_idle", 32'(busy), 32'h0);

    // rr=1 now: lane 0 still wins alone, dat[0] = 1,0,0 -> parity 1, then stall.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    tick();
    checkOutput("b_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0110, 1'b0);
    tick();
    applyStimulus(4'b0100, 4'b1111, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("b_hold_valid%0d", c), 32'(res_valid), 32'h1);
      checkOutput($sformatf("b_hold_par%0d", c), 32'(res_par), 32'h1);
      checkOutput($sformatf("b_hold_lane%0d", c), 32'(res_lane), 32'h0);
      checkOutput($sformatf("b_hold_gnt%0d", c), 32'(gnt), 32'h0);
      tick();
    end
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    tick();
    checkOutput("b_release_valid", 32'(res_valid), 32'h0);
    checkOutput("b_release_idle", 32'(busy), 32'h0);
    checkOutput("b_release_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    checkOutput("b_gnt_lane2", 32'(gnt), 32'h4);
    applyStimulus(4'b0000, 4'b0100, 1'b1);
    repeat (WIN) tick();
    checkOutput("b2_valid", 32'(res_valid), 32'h1);
    checkOutput("b2_par", 32'(res_par), 32'h1);
    checkOutput("b2_lane", 32'(res_lane), 32'h2);
    tick();

    // rr=3: start lane 2, reset after its second sample.
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    checkOutput("d_gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0000, 4'b0100, 1'b0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkAllZero("d_rst");
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    tick();
    checkAllZero("d_rst_held");
    rst = 1'b0;
    tick();
    checkOutput("d_first_gnt", 32'(gnt), 32'h1);
    checkOutput("d_novalid", 32'(res_valid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    repeat (WIN - 1) tick();
    checkOutput("d_novalid_late", 32'(res_valid), 32'h0);
    tick();
    checkOutput("d_valid", 32'(res_valid), 32'h1);
    checkOutput("d_lane", 32'(res_lane), 32'h0);
    tick();

    // rr=1: lane 2 wins, then withdraws its request after sample 1.
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    tick();
    checkOutput("e_gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    tick();
    applyStimulus(4'b0000, 4'b0100, 1'b1);
    tick();
`ifdef WIN_PARITY_SCHED_ABORT_EN
    checkOutput("e_abort_gnt", 32'(gnt), 32'h0);
    checkOutput("e_abort_idle", 32'(busy), 32'h0);
    checkOutput("e_abort_valid", 32'(res_valid), 32'h0);
    tick();
    checkOutput("e_abort_novalid", 32'(res_valid), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    tick();
    checkOutput("e_rr_kept", 32'(gnt), 32'h2);
`else
    checkOutput("e_keep_gnt", 32'(gnt), 32'h4);
    checkOutput("e_keep_busy", 32'(busy), 32'h1);
    checkOutput("e_keep_novalid", 32'(res_valid), 32'h0);
    tick();
    checkOutput("e_valid", 32'(res_valid), 32'h1);
    checkOutput("e_lane", 32'(res_lane), 32'h2);
    checkOutput("e_par", 32'(res_par), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
